// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: decodes op/funct, drives datapath selects and
// enables, and stalls on a variable-latency shared memory port with a wait timeout.
module multicycle_control_fsm #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       memread,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic       regdst,
   output logic [1:0] memtoreg,
   output logic       regwrite,
   output logic       halted,
   output logic [3:0] state
);

   localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_LUIWB  = 4'd12,
      S_HALT   = 4'd15
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             in_wait;
   logic [2:0]       rt_alu;
   logic             rt_valid;

   // The branch decision on zero is taken by the datapath's PC-enable logic.
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // R-type funct decode, shared by sequencing and ALU control.
   always_comb begin
      rt_alu   = 3'b000;
      rt_valid = 1'b1;
      case (funct)
         6'b100000: rt_alu = 3'b101;
         6'b100010: rt_alu = 3'b001;
         6'b100100: rt_alu = 3'b111;
         6'b100101: rt_alu = 3'b110;
         6'b101010: rt_alu = 3'b000;
         default:   rt_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      in_wait    = 1'b0;
      case (state_q)
         S_FETCH: begin
            in_wait = 1'b1;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:    state_d = S_MEMADR;
               OP_RTYPE:        state_d = S_RTEXEC;
               OP_BEQ:          state_d = S_BRANCH;
               OP_ADDI, OP_ORI: state_d = S_IEXEC;
               OP_J:            state_d = S_JUMP;
               OP_LUI:          state_d = S_LUIWB;
               default:         state_d = S_HALT;
            endcase
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            in_wait = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWR: begin
            in_wait = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_RTEXEC: state_d = rt_valid ? S_ALUWB : S_HALT;
         S_IEXEC:  state_d = S_IWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_LUIWB: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_HALT;
      endcase

      // Timeout: the cycle that brings the count to MAX_WAIT sends us to HALT.
      if (in_wait && !mem_ready && (MAX_WAIT != 0)) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
         if (wait_cnt_d == CNT_W'(MAX_WAIT)) state_d = S_HALT;
      end
      if (state_d != state_q) wait_cnt_d = '0;
   end

   always_comb begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b000;
      regdst     = 1'b0;
      memtoreg   = 2'b00;
      regwrite   = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            memread    = 1'b1;
            alusrcb    = 2'b01;
            alucontrol = 3'b101;
            irwrite    = mem_ready;
            pcwrite    = mem_ready;
         end
         S_DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = 3'b101;
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = 3'b101;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            memtoreg = 2'b01;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_RTEXEC: begin
            alusrca    = 1'b1;
            alucontrol = rt_alu;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 3'b001;
            branch     = 1'b1;
            pcsrc      = 2'b01;
         end
         S_IEXEC: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = (op == OP_ORI) ? 3'b110 : 3'b101;
         end
         S_IWB:   regwrite = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_LUIWB: begin
            memtoreg = 2'b10;
            regwrite = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: halted = 1'b1;
      endcase

      // Reset kills every enable immediately so an in-flight access cannot complete.
      if (reset) begin
         memread  = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         pcwrite  = 1'b0;
         branch   = 1'b0;
         regwrite = 1'b0;
         halted   = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scoreboard bench for multicycle_control_fsm: expected state and control
// word are queued per cycle and checked against the DUT with immediate assertions.
module tb_multicycle_control_fsm;

   logic       clk;
   logic       reset_a, reset_b;
   logic       mem_ready_a, mem_ready_b;
   logic [5:0] op, funct;
   logic       zero;

   logic memread_a, memwrite_a, iord_a, irwrite_a, pcwrite_a, branch_a;
   logic alusrca_a, regdst_a, regwrite_a, halted_a;
   logic [1:0] pcsrc_a, alusrcb_a, memtoreg_a;
   logic [2:0] alucontrol_a;
   logic [3:0] state_a;

   logic memread_b, memwrite_b, iord_b, irwrite_b, pcwrite_b, branch_b;
   logic alusrca_b, regdst_b, regwrite_b, halted_b;
   logic [1:0] pcsrc_b, alusrcb_b, memtoreg_b;
   logic [2:0] alucontrol_b;
   logic [3:0] state_b;

   logic [18:0] ctrl_a, ctrl_b;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        which;
      logic [3:0]  st;
      logic [18:0] ctrl;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   // Control word: {memread,memwrite,iord,irwrite,pcwrite,branch,pcsrc,alusrca,alusrcb,alucontrol,regdst,memtoreg,regwrite,halted}
   localparam logic [18:0] C_FETCH0 = {1'b1, 5'b0, 2'b00, 1'b0, 2'b01, 3'b101, 5'b0};
   localparam logic [18:0] C_FETCH1 = {1'b1, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, 3'b101, 5'b0};
   localparam logic [18:0] C_RESET  = {6'b0, 2'b00, 1'b0, 2'b01, 3'b101, 5'b0};
   localparam logic [18:0] C_DECODE = {6'b0, 2'b00, 1'b0, 2'b11, 3'b101, 5'b0};
   localparam logic [18:0] C_MEMADR = {6'b0, 2'b00, 1'b1, 2'b10, 3'b101, 5'b0};
   localparam logic [18:0] C_MEMRD  = {3'b101, 16'b0};
   localparam logic [18:0] C_MEMWR  = {3'b011, 16'b0};
   localparam logic [18:0] C_SWRST  = {3'b001, 16'b0};
   localparam logic [18:0] C_MEMWB  = {14'b0, 1'b0, 2'b01, 1'b1, 1'b0};
   localparam logic [18:0] C_ALUWB  = {14'b0, 1'b1, 2'b00, 1'b1, 1'b0};
   localparam logic [18:0] C_IWB    = {17'b0, 1'b1, 1'b0};
   localparam logic [18:0] C_LUIWB  = {14'b0, 1'b0, 2'b10, 1'b1, 1'b0};
   localparam logic [18:0] C_BRANCH = {5'b0, 1'b1, 2'b01, 1'b1, 2'b00, 3'b001, 5'b0};
   localparam logic [18:0] C_JUMP   = {4'b0, 1'b1, 1'b0, 2'b10, 11'b0};
   localparam logic [18:0] C_HALT   = 19'd1;
   localparam logic [18:0] C_NONE   = 19'd0;

   function automatic logic [18:0] c_rtexec(input logic [2:0] a);
      return {8'b0, 1'b1, 2'b00, a, 5'b0};
   endfunction

   function automatic logic [18:0] c_iexec(input logic [2:0] a);
      return {8'b0, 1'b1, 2'b10, a, 5'b0};
   endfunction

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset_a), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready_a), .memread(memread_a), .memwrite(memwrite_a),
      .iord(iord_a), .irwrite(irwrite_a), .pcwrite(pcwrite_a), .branch(branch_a),
      .pcsrc(pcsrc_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a),
      .alucontrol(alucontrol_a), .regdst(regdst_a), .memtoreg(memtoreg_a),
      .regwrite(regwrite_a), .halted(halted_a), .state(state_a)
   );

   multicycle_control_fsm #(.MAX_WAIT(4)) dut4 (
      .clk(clk), .reset(reset_b), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready_b), .memread(memread_b), .memwrite(memwrite_b),
      .iord(iord_b), .irwrite(irwrite_b), .pcwrite(pcwrite_b), .branch(branch_b),
      .pcsrc(pcsrc_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
      .alucontrol(alucontrol_b), .regdst(regdst_b), .memtoreg(memtoreg_b),
      .regwrite(regwrite_b), .halted(halted_b), .state(state_b)
   );

   assign ctrl_a = {memread_a, memwrite_a, iord_a, irwrite_a, pcwrite_a, branch_a, pcsrc_a,
                    alusrca_a, alusrcb_a, alucontrol_a, regdst_a, memtoreg_a, regwrite_a, halted_a};
   assign ctrl_b = {memread_b, memwrite_b, iord_b, irwrite_b, pcwrite_b, branch_b, pcsrc_b,
                    alusrca_b, alusrcb_b, alucontrol_b, regdst_b, memtoreg_b, regwrite_b, halted_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called just after a falling edge with inputs set: queue, check, advance one cycle.
   task automatic step(input string tag, input logic which, input logic [3:0] st,
                       input logic [18:0] c);
      exp_t        e;
      string       t;
      logic [3:0]  obs_st;
      logic [18:0] obs_c;
      exp_q.push_back('{which: which, st: st, ctrl: c});
      tag_q.push_back(tag);
      #1;
      e      = exp_q.pop_front();
      t      = tag_q.pop_front();
      obs_st = e.which ? state_b : state_a;
      obs_c  = e.which ? ctrl_b : ctrl_a;
      n_assert++;
      assert (obs_st === e.st) else begin
         n_fail++;
         $error("FAIL %s state: observed %0d expected %0d", t, obs_st, e.st);
      end
      n_assert++;
      assert (obs_c === e.ctrl) else begin
         n_fail++;
         $error("FAIL %s ctrl: observed %b expected %b", t, obs_c, e.ctrl);
      end
      @(negedge clk);
   endtask

   initial begin
      reset_a     = 1'b1;
      reset_b     = 1'b1;
      mem_ready_a = 1'b1;
      mem_ready_b = 1'b0;
      op          = 6'b000000;
      funct       = 6'b100000;
      zero        = 1'b0;
      @(negedge clk);

      step("rst0", 1'b0, 4'd0, C_RESET);
      step("rst1", 1'b0, 4'd0, C_RESET);
      reset_a = 1'b0;

      // add
      step("add_fetch", 1'b0, 4'd0, C_FETCH1);
      step("add_dec",   1'b0, 4'd1, C_DECODE);
      step("add_exec",  1'b0, 4'd6, c_rtexec(3'b101));
      step("add_wb",    1'b0, 4'd7, C_ALUWB);

      // lw with three memory wait cycles; mem_ready high outside waits is ignored
      op = 6'b100011;
      step("lw_fetch",  1'b0, 4'd0, C_FETCH1);
      step("lw_dec",    1'b0, 4'd1, C_DECODE);
      step("lw_adr",    1'b0, 4'd2, C_MEMADR);
      mem_ready_a = 1'b0;
      for (int i = 0; i < 3; i++) step("lw_wait", 1'b0, 4'd3, C_MEMRD);
      mem_ready_a = 1'b1;
      step("lw_done",   1'b0, 4'd3, C_MEMRD);
      step("lw_wb",     1'b0, 4'd4, C_MEMWB);

      // sw with one wait cycle
      op = 6'b101011;
      step("sw_fetch",  1'b0, 4'd0, C_FETCH1);
      step("sw_dec",    1'b0, 4'd1, C_DECODE);
      step("sw_adr",    1'b0, 4'd2, C_MEMADR);
      mem_ready_a = 1'b0;
      step("sw_wait",   1'b0, 4'd5, C_MEMWR);
      mem_ready_a = 1'b1;
      step("sw_done",   1'b0, 4'd5, C_MEMWR);

      // beq, lui, addi, ori, j
      op = 6'b000100; zero = 1'b1;
      step("beq_fetch", 1'b0, 4'd0, C_FETCH1);
      step("beq_dec",   1'b0, 4'd1, C_DECODE);
      step("beq_br",    1'b0, 4'd8, C_BRANCH);
      op = 6'b001111; zero = 1'b0;
      step("lui_fetch", 1'b0, 4'd0, C_FETCH1);
      step("lui_dec",   1'b0, 4'd1, C_DECODE);
      step("lui_wb",    1'b0, 4'd12, C_LUIWB);
      op = 6'b001000;
      step("addi_fetch", 1'b0, 4'd0, C_FETCH1);
      step("addi_dec",   1'b0, 4'd1, C_DECODE);
      step("addi_exec",  1'b0, 4'd9, c_iexec(3'b101));
      step("addi_wb",    1'b0, 4'd10, C_IWB);
      op = 6'b001101;
      step("ori_fetch", 1'b0, 4'd0, C_FETCH1);
      step("ori_dec",   1'b0, 4'd1, C_DECODE);
      step("ori_exec",  1'b0, 4'd9, c_iexec(3'b110));
      step("ori_wb",    1'b0, 4'd10, C_IWB);
      op = 6'b000010;
      step("j_fetch",   1'b0, 4'd0, C_FETCH1);
      step("j_dec",     1'b0, 4'd1, C_DECODE);
      step("j_jump",    1'b0, 4'd11, C_JUMP);

      // illegal opcode: sticky HALT regardless of mem_ready
      op = 6'b111111;
      step("ill_fetch", 1'b0, 4'd0, C_FETCH1);
      step("ill_dec",   1'b0, 4'd1, C_DECODE);
      for (int i = 0; i < 20; i++) begin
         mem_ready_a = 1'(i % 2);
         step("ill_halt", 1'b0, 4'd15, C_HALT);
      end
      mem_ready_a = 1'b1;
      reset_a = 1'b1;
      step("ill_rst",   1'b0, 4'd15, C_NONE);
      step("ill_rst2",  1'b0, 4'd0, C_RESET);
      reset_a = 1'b0;

      // illegal funct: no writeback, HALT
      op = 6'b000000; funct = 6'b000111;
      step("fn_fetch",  1'b0, 4'd0, C_FETCH1);
      step("fn_dec",    1'b0, 4'd1, C_DECODE);
      step("fn_exec",   1'b0, 4'd6, c_rtexec(3'b000));
      for (int i = 0; i < 3; i++) step("fn_halt", 1'b0, 4'd15, C_HALT);
      reset_a = 1'b1;
      step("fn_rst",    1'b0, 4'd15, C_NONE);
      step("fn_rst2",   1'b0, 4'd0, C_RESET);
      reset_a = 1'b0; funct = 6'b100000;

      // reset in the middle of a store
      op = 6'b101011;
      step("swr_fetch", 1'b0, 4'd0, C_FETCH1);
      step("swr_dec",   1'b0, 4'd1, C_DECODE);
      step("swr_adr",   1'b0, 4'd2, C_MEMADR);
      mem_ready_a = 1'b0;
      step("swr_wait",  1'b0, 4'd5, C_MEMWR);
      reset_a = 1'b1;
      step("swr_rst",   1'b0, 4'd5, C_SWRST);
      reset_a = 1'b0;
      step("swr_after", 1'b0, 4'd0, C_FETCH0);
      reset_a = 1'b1;

      // MAX_WAIT=4 instance: fetch never completes
      reset_b = 1'b0;
      for (int i = 0; i < 4; i++) step("to_wait", 1'b1, 4'd0, C_FETCH0);
      step("to_halt",  1'b1, 4'd15, C_HALT);
      step("to_halt2", 1'b1, 4'd15, C_HALT);
      reset_b = 1'b1;
      step("to_rst",   1'b1, 4'd15, C_NONE);
      step("to_rst2",  1'b1, 4'd0, C_RESET);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control FSM that sequences a multicycle variant of the MIPS datapath: shared ALU, one shared instruction/data memory port, instruction register, ALUOut register.
- Decodes opcode/funct and drives the existing control encodings: alucontrol (000 SLT, 001 SUB, 101 ADD, 110 OR, 111 AND) and memtoreg (00 ALU, 01 memory, 10 LUI).
- Stalls on a variable-latency memory handshake.

Parameters:
- MAX_WAIT, 255, memory wait-cycle limit before timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current access this cycle
- memread  out  1  read request; held until mem_ready
- memwrite  out  1  write request; held until mem_ready
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load the instruction register
- pcwrite  out  1  unconditional PC load
- branch  out  1  PC load if zero
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
- alucontrol  out  3  ALU operation, encoding as above
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  2  writeback select, encoding as above
- regwrite  out  1  register file write enable
- halted  out  1  high in HALT
- state  out  4  current state, for debug

Behaviour:
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, LUIWB=12, HALT=15.
- Reset: state<=FETCH.
- While reset is high, force to 0: all enables (memread, memwrite, irwrite, pcwrite, branch, regwrite) and halted.
- Default outputs: all 0 unless listed per state below.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=101, pcsrc=00.
  - irwrite=pcwrite=mem_ready (Mealy).
  - Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE: alusrca=0, alusrcb=11, alucontrol=101 (branch target into ALUOut). Next state by op:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R-type -> RTEXEC
  - 000100 beq -> BRANCH
  - 001000 addi / 001101 ori -> IEXEC
  - 000010 j -> JUMP
  - 001111 lui -> LUIWB
  - any other op -> HALT
- MEMADR: alusrca=1, alusrcb=10, alucontrol=101. lw -> MEMRD; sw -> MEMWR.
- MEMRD: memread=1, iord=1; wait for mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=01, regwrite=1 -> FETCH.
- MEMWR: memwrite=1, iord=1; wait for mem_ready, then FETCH.
- RTEXEC: alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000 -> 101
  - 100010 -> 001
  - 100100 -> 111
  - 100101 -> 110
  - 101010 -> 000
  - other funct -> HALT (no writeback)
- ALUWB: regdst=1, memtoreg=00, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=001, branch=1, pcsrc=01 -> FETCH. The PC update depends on zero externally.
- IEXEC: alusrca=1, alusrcb=10, alucontrol=101 for addi, 110 for ori -> IWB. ori uses sign-extended imm, consistent with the existing datapath.
- IWB: regdst=0, memtoreg=00, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- LUIWB: regdst=0, memtoreg=10, regwrite=1 -> FETCH.
- HALT: halted=1; all enables 0; sticky until reset.
- Latency (mem_ready immediate): lw 5, sw 4, R/addi/ori 4, beq 3, j 3, lui 3 cycles. Each memory wait cycle adds 1.
- Wait counter:
  - Cleared on entry to any wait state (FETCH, MEMRD, MEMWR); counts cycles while mem_ready=0.
  - If MAX_WAIT != 0 and the count reaches MAX_WAIT -> HALT; the request is dropped the next cycle.
- mem_ready outside a wait state is ignored.
- memread and memwrite are never both high.
- Reset mid-access: request deasserts the following cycle, no write enable pulses, restart at FETCH.

Test Plan:
- Reset held 2 cycles, then release with mem_ready=1, op=000000 funct=100000 -> states 0,1,6,7,0. alucontrol=101 in RTEXEC. regwrite=1, regdst=1 only in ALUWB.
- lw (op=100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with memread=1, iord=1. Then MEMWB with memtoreg=01, regwrite=1.
- sw (op=101011) -> MEMWR with memwrite=1, memread=0. Never regwrite. Back to FETCH after mem_ready.
- beq (op=000100) -> BRANCH with alucontrol=001, branch=1, pcsrc=01, pcwrite=0. lui (op=001111) -> LUIWB with memtoreg=10.
- op=111111, or R-type funct=000111 -> HALT, halted=1, all enables 0 for 20 cycles. Reset -> FETCH.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH -> HALT after 4 wait cycles. Reset asserted during MEMWR -> memwrite=0 next cycle, state=0.
